// File: rtl/serial_shift_reg.sv
// Serial-in, parallel-out shift register; one bit captured per enabled rising edge of clk.
// Latency: a bit sampled at an edge appears on srOut right after that edge; srOut comes straight from the flops.
// Backpressure: none; en=0 holds the contents and synchronous rst overrides en and serIn.
// Build option SHIFTREG_LSB_IN_EN: serIn enters bit 0 and the register shifts toward the MSB.
// Default build (macro undefined): serIn enters bit WIDTH-1 and the register shifts toward the LSB.
module serial_shift_reg #(
  parameter int               WIDTH   = 6,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             serIn,
  input  logic             clk,
  input  logic             en,
  input  logic             rst,
  output logic [WIDTH-1:0] srOut
);

  logic [WIDTH-1:0] sr_q;
  logic [WIDTH-1:0] sr_d;

  // Next contents: shift one position when enabled, otherwise hold.
  always_comb begin
    sr_d = sr_q;
    if (en) begin
`ifdef SHIFTREG_LSB_IN_EN
      sr_d = {sr_q[WIDTH-2:0], serIn};
`else
      sr_d = {serIn, sr_q[WIDTH-1:1]};
`endif
    end
  end

  // Register update; reset takes priority over enable and data.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= RST_VAL;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign srOut = sr_q;

endmodule

// File: tb/tb_serial_shift_reg.sv
// Self-checking bench for serial_shift_reg: directed cases plus random traffic against a reference model.
// Inputs change on the falling edge, and outputs are sampled 1 time unit after the rising edge.
// The reference model treats the register as an integer that is shifted and masked.
module tb_serial_shift_reg;
  localparam int W = 6;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         serIn;
  logic [W-1:0] srOut;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] mdl;

  always #5 clk = ~clk;

  serial_shift_reg #(.WIDTH(W)) dut (
    .serIn (serIn),
    .clk   (clk),
    .en    (en),
    .rst   (rst),
    .srOut (srOut)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %b expected %b", tag, obs[W-1:0], exp[W-1:0]);
    end
  endtask

  // Reference: an MSB-in register behaves as value/2 + bit*2^(W-1).
  // An LSB-in register behaves as (value*2 + bit) mod 2^W.
  function automatic logic [W-1:0] model_next(input logic [W-1:0] cur, input logic r, input logic e,
                                              input logic s);
    longint unsigned v;
    v = longint'(cur);
    if (r) return '0;
    if (!e) return cur;
`ifdef SHIFTREG_LSB_IN_EN
    v = (v * 2 + longint'(s)) % (64'd1 << W);
`else
    v = v / 2 + longint'(s) * (64'd1 << (W - 1));
`endif
    return v[W-1:0];
  endfunction

  // One clock: check stability over the falling edge, drive inputs, then check after the rising edge.
  task automatic step(input logic r, input logic e, input logic s);
    @(negedge clk);
    if (!$isunknown(mdl)) check("fall_hold", srOut, mdl);
    rst = r; en = e; serIn = s;
    @(posedge clk);
    mdl = model_next(mdl, r, e, s);
    #1;
    check("edge", srOut, mdl);
  endtask

  initial begin
    logic [5:0] pat;
    rst = 1'b0; en = 1'b0; serIn = 1'b0;
    mdl = 'x;

    // Reset wins over en and serIn.
    step(1'b1, 1'b1, 1'b1);
    check("rst_val", srOut, 6'b000000);

`ifndef SHIFTREG_LSB_IN_EN
    step(1'b0, 1'b1, 1'b1);
    check("first_bit", srOut, 6'b100000);

    // serIn glitches high and then settles low before the edge: only the edge value is captured.
    @(negedge clk);
    en = 1'b1; serIn = 1'b1;
    #2 serIn = 1'b0;
    @(posedge clk);
    mdl = model_next(mdl, 1'b0, 1'b1, 1'b0);
    #1;
    check("sample_edge", srOut, 6'b010000);
    step(1'b0, 1'b1, 1'b0);
    check("sample_next", srOut, 6'b001000);

    // Fill with ones from reset, then flush with zeros.
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, 1'b1);
    check("fill", srOut, 6'b111111);
    pat = 6'b011111;
    for (int i = 0; i < W; i++) begin
      step(1'b0, 1'b1, 1'b0);
      check("flush", srOut, pat);
      pat = pat >> 1;
    end

    // Load 101100 (the earliest bit ends up at the LSB), then hold while serIn toggles.
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    check("load", srOut, 6'b101100);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'(i % 2));
    check("hold", srOut, 6'b101100);
    step(1'b0, 1'b1, 1'b1);
    check("resume", srOut, 6'b110110);

    // Reset in the middle of the stream, with en and serIn also high.
    for (int i = 0; i < W; i++) step(1'b0, 1'b1, 1'b1);
    check("full_again", srOut, 6'b111111);
    step(1'b1, 1'b1, 1'b1);
    check("rst_prio", srOut, 6'b000000);
    @(negedge clk);
    check("rst_fall", srOut, 6'b000000);
    @(posedge clk);
    rst = 1'b0; en = 1'b0;
    #3;
    check("high_level", srOut, 6'b000000);
`else
    step(1'b0, 1'b1, 1'b1);
    check("lsb_1", srOut, 6'b000001);
    step(1'b0, 1'b1, 1'b1);
    check("lsb_2", srOut, 6'b000011);
    step(1'b0, 1'b1, 1'b0);
    check("lsb_3", srOut, 6'b000110);
`endif

    // Random traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
